// File: rtl/bcd_arith_if.sv
// bcd_arith_if: operand/result bundle between the control FSM and the BCD arithmetic stage.
//   start      : one-cycle strobe that starts an operation
//   op         : 00 add, 01 subtract, 10 multiply, 11 invalid
//   a_bcd/b_bcd: operands, digit 0 (units) in bits [3:0]
//   busy/done  : stage busy, one-cycle completion pulse
//   result_bcd : result magnitude; negative/overflow/error flags
interface bcd_arith_if #(
  parameter int unsigned NDIGITS = 3
);
  logic                   start;
  logic [1:0]             op;
  logic [4*NDIGITS-1:0]   a_bcd;
  logic [4*NDIGITS-1:0]   b_bcd;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS-1:0]   result_bcd;
  logic                   negative;
  logic                   overflow;
  logic                   error;

  modport master (
    output start, op, a_bcd, b_bcd,
    input  busy, done, result_bcd, negative, overflow, error
  );

  modport slave (
    input  start, op, a_bcd, b_bcd,
    output busy, done, result_bcd, negative, overflow, error
  );
endinterface

// File: rtl/bcd_arith_unit.sv
// bcd_arith_unit: digit-serial BCD add / subtract / multiply, one digit per clock.
//   i_clock : system clock, rising edge
//   i_reset : synchronous active-high reset
//   io_bus  : bcd_arith_if slave (start/op/operands in, busy/done/result/flags out)
// Multiply is repeated addition of A into an accumulator, B times.
module bcd_arith_unit #(
  parameter int unsigned NDIGITS = 3
) (
  input  logic       i_clock,
  input  logic       i_reset,
  bcd_arith_if.slave io_bus
);
  localparam int unsigned W  = 4 * NDIGITS;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LastIdx  = IW'(NDIGITS - 1);
  localparam logic [W-1:0]  AllNines = {NDIGITS{4'h9}};
  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;

  typedef enum logic [2:0] {StIdle, StCheck, StCmp, StDigit, StMtest, StFin} state_e;

  state_e          r_state, w_state_next;
  logic [W-1:0]    r_a, w_a_next;
  logic [W-1:0]    r_b, w_b_next;
  logic [1:0]      r_op, w_op_next;
  logic [W-1:0]    r_acc, w_acc_next;
  logic [W-1:0]    r_cnt, w_cnt_next;
  logic [IW-1:0]   r_idx, w_idx_next;
  logic            r_carry, w_carry_next;
  logic            r_swap, w_swap_next;
  logic [W-1:0]    r_res, w_res_next;
  logic            r_neg, w_neg_next;
  logic            r_ovf, w_ovf_next;
  logic            r_err, w_err_next;

  int              w_base;
  logic [3:0]      w_x, w_y, w_dig;
  logic [4:0]      w_t;
  logic            w_cout;
  logic [W-1:0]    w_acc_dig;
  logic [W-1:0]    w_cnt_dec;
  logic            w_dec_borrow;
  logic            w_bad;

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_op_next    = r_op;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_carry_next = r_carry;
    w_swap_next  = r_swap;
    w_res_next   = r_res;
    w_neg_next   = r_neg;
    w_ovf_next   = r_ovf;
    w_err_next   = r_err;

    // One digit of add/sub; multiply adds A into the accumulator digit.
    w_base = int'(r_idx) * 4;
    w_x    = (r_op == OpMul) ? r_acc[w_base +: 4] : r_a[w_base +: 4];
    w_y    = (r_op == OpMul) ? r_a[w_base +: 4]   : r_b[w_base +: 4];
    w_cout = 1'b0;
    if (r_op == OpSub) begin
      w_t = {1'b0, w_y} + {4'b0, r_carry};
      if ({1'b0, w_x} < w_t) begin
        w_dig  = 4'({1'b0, w_x} + 5'd10 - w_t);
        w_cout = 1'b1;
      end else begin
        w_dig = 4'({1'b0, w_x} - w_t);
      end
    end else begin
      w_t = {1'b0, w_x} + {1'b0, w_y} + {4'b0, r_carry};
      if (w_t > 5'd9) begin
        w_dig  = 4'(w_t - 5'd10);
        w_cout = 1'b1;
      end else begin
        w_dig = w_t[3:0];
      end
    end
    w_acc_dig = r_acc;
    w_acc_dig[w_base +: 4] = w_dig;

    // BCD decrement of the multiply counter (100 -> 099).
    w_cnt_dec    = r_cnt;
    w_dec_borrow = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (w_dec_borrow) begin
        if (r_cnt[i*4 +: 4] == 4'd0) begin
          w_cnt_dec[i*4 +: 4] = 4'd9;
        end else begin
          w_cnt_dec[i*4 +: 4] = r_cnt[i*4 +: 4] - 4'd1;
          w_dec_borrow        = 1'b0;
        end
      end
    end

    w_bad = (r_op == 2'b11);
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_a[i*4 +: 4] > 4'd9 || r_b[i*4 +: 4] > 4'd9) w_bad = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_a_next     = io_bus.a_bcd;
          w_b_next     = io_bus.b_bcd;
          w_op_next    = io_bus.op;
          w_swap_next  = 1'b0;
          w_state_next = StCheck;
        end
      end
      StCheck: begin
        w_idx_next   = '0;
        w_carry_next = 1'b0;
        w_acc_next   = '0;
        w_cnt_next   = r_b;
        if (w_bad) begin
          w_res_next   = '0;
          w_neg_next   = 1'b0;
          w_ovf_next   = 1'b0;
          w_err_next   = 1'b1;
          w_state_next = StFin;
        end else if (r_op == OpAdd) begin
          w_state_next = StDigit;
        end else if (r_op == OpSub) begin
          w_state_next = StCmp;
        end else begin
          w_state_next = StMtest;
        end
      end
      StCmp: begin
        // Valid BCD orders the same as plain binary, so a binary compare suffices.
        if (r_a < r_b) begin
          w_a_next    = r_b;
          w_b_next    = r_a;
          w_swap_next = 1'b1;
        end
        w_state_next = StDigit;
      end
      StDigit: begin
        w_acc_next   = w_acc_dig;
        w_carry_next = w_cout;
        w_idx_next   = r_idx + 1'b1;
        if (r_idx == LastIdx) begin
          if (w_cout && r_op != OpSub) begin
            w_res_next   = AllNines;
            w_neg_next   = 1'b0;
            w_ovf_next   = 1'b1;
            w_err_next   = 1'b0;
            w_state_next = StFin;
          end else if (r_op == OpMul) begin
            w_state_next = StMtest;
          end else begin
            w_res_next   = w_acc_dig;
            w_neg_next   = r_swap && (w_acc_dig != '0);
            w_ovf_next   = 1'b0;
            w_err_next   = 1'b0;
            w_state_next = StFin;
          end
        end
      end
      StMtest: begin
        if (r_cnt == '0) begin
          w_res_next   = r_acc;
          w_neg_next   = 1'b0;
          w_ovf_next   = 1'b0;
          w_err_next   = 1'b0;
          w_state_next = StFin;
        end else begin
          w_cnt_next   = w_cnt_dec;
          w_idx_next   = '0;
          w_carry_next = 1'b0;
          w_state_next = StDigit;
        end
      end
      StFin: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_swap  <= 1'b0;
      r_res   <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_op    <= w_op_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_carry <= w_carry_next;
      r_swap  <= w_swap_next;
      r_res   <= w_res_next;
      r_neg   <= w_neg_next;
      r_ovf   <= w_ovf_next;
      r_err   <= w_err_next;
    end
  end

  assign io_bus.busy       = (r_state != StIdle);
  assign io_bus.done       = (r_state == StFin);
  assign io_bus.result_bcd = r_res;
  assign io_bus.negative   = r_neg;
  assign io_bus.overflow   = r_ovf;
  assign io_bus.error      = r_err;
endmodule
